// File: rtl/anchor_frame_loader.sv
// anchor_frame_loader: gathers one 16-beat anchor frame (4 anchors x {x,y,z,r}, raw
// IEEE-754 double bits) from a valid/ready stream, commits it to parallel buses,
// then holds the solver enable until the solver's done flag rises.
// Optional feature: define FRAME_TIMEOUT_EN to abort stalled frames and hung solves
// after TIMEOUT_CYCLES cycles.
module anchor_frame_loader #(
    parameter int unsigned COUNT_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    input  logic               in_last,
    output logic [63:0]        x1,
    output logic [63:0]        y1,
    output logic [63:0]        z1,
    output logic [63:0]        r1,
    output logic [63:0]        x2,
    output logic [63:0]        y2,
    output logic [63:0]        z2,
    output logic [63:0]        r2,
    output logic [63:0]        x3,
    output logic [63:0]        y3,
    output logic [63:0]        z3,
    output logic [63:0]        r3,
    output logic [63:0]        x4,
    output logic [63:0]        y4,
    output logic [63:0]        z4,
    output logic [63:0]        r4,
    output logic               solve_en,
    input  logic               solver_done,
    output logic               frame_err,
    output logic [COUNT_W-1:0] frames_done
);

    typedef enum logic [0:0] {StLoad, StSolve} state_e;

    state_e             state_q, state_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic [63:0]        shadow_q [15];
    logic [63:0]        bus_q [16];
    logic               solve_en_q, solve_en_d;
    logic               frame_err_q, frame_err_d;
    logic [COUNT_W-1:0] frames_done_q, frames_done_d;
    logic               done_q;
    logic               handshake, done_rise, commit, tmo_hit;

    assign in_ready  = (state_q == StLoad);
    assign handshake = in_valid && in_ready;
    // A level already high when SOLVE is entered leaves done_q high, so no rise is seen.
    assign done_rise = solver_done && !done_q;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Stall counter: runs on an idle partial frame or an unanswered solve.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if ((state_q == StLoad && !handshake && beat_cnt_q != 4'd0) ||
            (state_q == StSolve && !done_rise)) begin
            if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic for the LOAD/SOLVE sequencer and its registered outputs.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        solve_en_d    = solve_en_q;
        frame_err_d   = 1'b0;
        frames_done_d = frames_done_q;
        commit        = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (handshake) begin
                    if (beat_cnt_q == 4'd15) begin
                        beat_cnt_d = 4'd0;
                        if (in_last) begin
                            commit     = 1'b1;
                            state_d    = StSolve;
                            solve_en_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        beat_cnt_d  = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    beat_cnt_d  = 4'd0;
                end
            end
            StSolve: begin
                if (done_rise) begin
                    solve_en_d    = 1'b0;
                    frames_done_d = frames_done_q + COUNT_W'(1);
                    state_d       = StLoad;
                end else if (tmo_hit) begin
                    solve_en_d  = 1'b0;
                    frame_err_d = 1'b1;
                    state_d     = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StLoad;
            beat_cnt_q    <= 4'd0;
            solve_en_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_done_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            solve_en_q    <= solve_en_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
            done_q        <= solver_done;
        end
    end

    // Shadow store for beats 0..14; beat 15 goes straight to the bus on commit.
    always_ff @(posedge clk) begin
        if (handshake && beat_cnt_q != 4'd15) begin
            shadow_q[beat_cnt_q] <= in_data;
        end
    end

    // Committed output buses: change only on commit or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bus_q[i] <= 64'd0;
        end else if (commit) begin
            for (int i = 0; i < 15; i++) bus_q[i] <= shadow_q[i];
            bus_q[15] <= in_data;
        end
    end

    assign x1 = bus_q[0];
    assign y1 = bus_q[1];
    assign z1 = bus_q[2];
    assign r1 = bus_q[3];
    assign x2 = bus_q[4];
    assign y2 = bus_q[5];
    assign z2 = bus_q[6];
    assign r2 = bus_q[7];
    assign x3 = bus_q[8];
    assign y3 = bus_q[9];
    assign z3 = bus_q[10];
    assign r3 = bus_q[11];
    assign x4 = bus_q[12];
    assign y4 = bus_q[13];
    assign z4 = bus_q[14];
    assign r4 = bus_q[15];

    assign solve_en    = solve_en_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_anchor_frame_loader.sv
// Scoreboard bench for anchor_frame_loader: stimulus pushes expected frames and
// expected frame_err events; a monitor pops them when the DUT commits or flags.
module tb_anchor_frame_loader;

    typedef logic [15:0][63:0] frame_t;

    localparam logic [63:0] Ten  = 64'h4024000000000000;
    localparam logic [63:0] Five = 64'h4014000000000000;
`ifdef FRAME_TIMEOUT_EN
    localparam int DoneWait = 10;
`else
    localparam int DoneWait = 19;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        in_last = 1'b0;
    logic [63:0] x1, y1, z1, r1, x2, y2, z2, r2, x3, y3, z3, r3, x4, y4, z4, r4;
    logic        solve_en;
    logic        solver_done = 1'b0;
    logic        frame_err;
    logic [7:0]  frames_done;
    frame_t      bus_now;

    int n_checks = 0;
    int n_pass   = 0;

    frame_t exp_frames[$];
    int     exp_errs[$];

    anchor_frame_loader #(
        .COUNT_W        (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .x1 (x1), .y1 (y1), .z1 (z1), .r1 (r1),
        .x2 (x2), .y2 (y2), .z2 (z2), .r2 (r2),
        .x3 (x3), .y3 (y3), .z3 (z3), .r3 (r3),
        .x4 (x4), .y4 (y4), .z4 (z4), .r4 (r4),
        .solve_en    (solve_en),
        .solver_done (solver_done),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    assign bus_now = {r4, z4, y4, x4, r3, z3, y3, x3, r2, z2, y2, x2, r1, z1, y1, x1};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (act[i] !== exp[i]) begin
                    $display("FAIL %s word %0d: got %h, expected %h", name, i, act[i], exp[i]);
                    break;
                end
            end
        end
    endtask

    function automatic frame_t mk_frame(input int tag);
        frame_t f;
        for (int i = 0; i < 16; i++) begin
            f[i] = 64'hC0DE_0000_0000_0000 | (64'(tag) << 16) | 64'(i);
        end
        return f;
    endfunction

    // Called and returns at posedge+1; beat is held until a handshake edge.
    task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
        bit r;
        int k;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        r = 1'b0;
        while (!r && k < 100) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!r) check("handshake_wait", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input bit gaps);
        for (int i = 0; i < 16; i++) send_beat(f[i], i == 15, gaps ? i % 6 : 0);
    endtask

    // Monitor: pops the scoreboard on commits and frame_err pulses; checks bus stability.
    initial begin : monitor
        frame_t cur;
        frame_t e;
        logic   se_prev;
        cur     = '0;
        se_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_frame("reset_buses", bus_now, '0);
                cur     = '0;
                se_prev = 1'b0;
            end else begin
                if (solve_en && !se_prev) begin
                    check("commit_expected", 64'(exp_frames.size() != 0), 64'd1);
                    if (exp_frames.size() != 0) begin
                        e = exp_frames.pop_front();
                        check_frame("commit_buses", bus_now, e);
                        cur = e;
                    end
                end else begin
                    check_frame("bus_stable", bus_now, cur);
                end
                if (frame_err) begin
                    check("frame_err_expected", 64'(exp_errs.size() != 0), 64'd1);
                    if (exp_errs.size() != 0) void'(exp_errs.pop_front());
                end
                if (in_valid && solve_en) check("ready_low_in_solve", in_ready, 1'b0);
                se_prev = solve_en;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        frame_t f1;
        int     lat;
        f1 = '0;
        f1[3]  = Five;
        f1[4]  = Ten;
        f1[7]  = Five;
        f1[9]  = Ten;
        f1[11] = Five;
        f1[14] = Ten;
        f1[15] = Five;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_solve_en", solve_en, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_frames_done", frames_done, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: commit
        exp_frames.push_back(f1);
        send_frame(f1, 1'b0);
        check("t1_solve_en", solve_en, 1'b1);
        check("t1_in_ready", in_ready, 1'b0);
        check("t1_x2", x2, Ten);
        check("t1_r4", r4, Five);

        // T2 + T4 blocking: in_valid held high with junk while solving
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        in_last  = 1'b1;
        repeat (DoneWait) @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        check("t2_solve_en", solve_en, 1'b0);
        check("t2_frames_done", frames_done, 8'd1);
        check("t2_in_ready", in_ready, 1'b1);
        check("t2_x2_kept", x2, Ten);

        // T3: early in_last on beat 6, then a normal frame with gaps
        exp_errs.push_back(2);
        for (int i = 0; i < 7; i++) send_beat(mk_frame(2)[i], i == 6, 0);
        @(posedge clk);
        #1;
        check("t3_x2_kept", x2, Ten);
        exp_frames.push_back(mk_frame(3));
        send_frame(mk_frame(3), 1'b1);
        check("t3_solve_en", solve_en, 1'b1);

        // solver_done still high from T2: a level is not a rise
        repeat (5) @(posedge clk);
        #1;
        check("held_done_solve_en", solve_en, 1'b1);
        check("held_done_count", frames_done, 8'd1);
        solver_done = 1'b0;
        @(posedge clk);
        #1;
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        check("rise_solve_en", solve_en, 1'b0);
        check("rise_frames_done", frames_done, 8'd2);
        solver_done = 1'b0;

        // in_last missing on beat 16: consumed, flagged, no commit
        exp_errs.push_back(4);
        for (int i = 0; i < 16; i++) send_beat(mk_frame(4)[i], 1'b0, 0);
        @(posedge clk);
        #1;
        check("no_last_solve_en", solve_en, 1'b0);
        check("no_last_in_ready", in_ready, 1'b1);

        // T5: reset after 8 beats
        for (int i = 0; i < 8; i++) send_beat(mk_frame(5)[i], 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("t5_x1_zero", x1, 64'd0);
        check("t5_frames_done", frames_done, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_frames.push_back(mk_frame(6));
        send_frame(mk_frame(6), 1'b1);
        check("t5_solve_en", solve_en, 1'b1);
        @(posedge clk);
        #1;
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        check("t5_frames_done_after", frames_done, 8'd1);
        solver_done = 1'b0;

`ifdef FRAME_TIMEOUT_EN
        // T6A: stall after 3 beats
        exp_errs.push_back(7);
        for (int i = 0; i < 3; i++) send_beat(mk_frame(7)[i], 1'b0, 0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (frame_err) lat = k;
        end
        check("t6a_latency", 64'(lat), 64'd16);
        // T6B: solver never answers
        exp_frames.push_back(mk_frame(8));
        exp_errs.push_back(8);
        send_frame(mk_frame(8), 1'b0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (!solve_en) lat = k;
            @(posedge clk);
            #1;
        end
        check("t6b_solve_en_dropped", 64'(lat != 0), 64'd1);
        check("t6b_frames_done", frames_done, 8'd1);
        check("t6b_in_ready", in_ready, 1'b1);
`else
        lat = 0;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("frames_left", 64'(exp_frames.size()), 64'd0);
        check("errs_left", 64'(exp_errs.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
